// File: rtl/regfile_writeback_queue_if.sv
// Bundle of producer handshake, register-file write port and bypass lookup
// signals for the writeback queue.
interface regfile_writeback_queue_if #(
  parameter int BITS_SIZE = 32,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 InValid;
  logic                 InReady;
  logic [4:0]           InRegister;
  logic [BITS_SIZE-1:0] InData;
  logic                 Hold;
  logic [4:0]           WriteRegister;
  logic [BITS_SIZE-1:0] WriteData;
  logic                 RegWrite;
  logic [4:0]           LookupRegister;
  logic                 LookupHit;
  logic [BITS_SIZE-1:0] LookupData;
  logic [CW-1:0]        Count;

  modport master (
    output InValid, InRegister, InData, Hold, LookupRegister,
    input  InReady, WriteRegister, WriteData, RegWrite, LookupHit, LookupData, Count
  );

  modport slave (
    input  InValid, InRegister, InData, Hold, LookupRegister,
    output InReady, WriteRegister, WriteData, RegWrite, LookupHit, LookupData, Count
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Write-side initiator for the register file: in-order FIFO of pending results,
// one registered write per cycle, and a youngest-first combinational bypass.
module regfile_writeback_queue #(
  parameter int BITS_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input logic                      Clk,
  input logic                      Rst_n,
  regfile_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]           regMem_q  [DEPTH];
  logic [BITS_SIZE-1:0] dataMem_q [DEPTH];
  logic [PW-1:0]        rdPtr_q, rdPtr_d;
  logic [PW-1:0]        wrPtr_q, wrPtr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 regWrite_q, regWrite_d;
  logic [4:0]           writeReg_q, writeReg_d;
  logic [BITS_SIZE-1:0] writeData_q, writeData_d;
  logic                 inReady, push, pop;
  logic                 lookupHit;
  logic [BITS_SIZE-1:0] lookupData;
  logic [PW-1:0]        idx;

  // Writes to $0 complete the handshake but are never stored.
  assign inReady = (count_q != CW'(DEPTH));
  assign push    = bus.InValid && inReady && (bus.InRegister != 5'd0);
  assign pop     = (count_q != '0) && !bus.Hold;

  always_comb begin
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    count_d     = count_q;
    regWrite_d  = pop;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    if (pop) begin
      rdPtr_d     = rdPtr_q + PW'(1);
      writeReg_d  = regMem_q[rdPtr_q];
      writeData_d = dataMem_q[rdPtr_q];
    end
    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
    end
  end

  // Storage is not reset; only slots below count_q are ever considered valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      regMem_q[wrPtr_q]  <= bus.InRegister;
      dataMem_q[wrPtr_q] <= bus.InData;
    end
  end

  // Scan oldest to youngest so the newest matching entry wins.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    idx        = rdPtr_q;
    if (bus.LookupRegister != 5'd0) begin
      if (regWrite_q && (writeReg_q == bus.LookupRegister)) begin
        lookupHit  = 1'b1;
        lookupData = writeData_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rdPtr_q + PW'(i);
        if ((CW'(i) < count_q) && (regMem_q[idx] == bus.LookupRegister)) begin
          lookupHit  = 1'b1;
          lookupData = dataMem_q[idx];
        end
      end
    end
  end

  assign bus.InReady       = inReady;
  assign bus.Count         = count_q;
  assign bus.RegWrite      = regWrite_q;
  assign bus.WriteRegister = writeReg_q;
  assign bus.WriteData     = writeData_q;
  assign bus.LookupHit     = lookupHit;
  assign bus.LookupData    = lookupData;
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_regfile_writeback_queue;
  localparam int BITS_SIZE = 32;
  localparam int DEPTH     = 4;
  localparam int CW        = $clog2(DEPTH) + 1;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } entry_t;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   failures;

  entry_t      mq[$];
  logic        mWe;
  logic [4:0]  mReg;
  logic [31:0] mData;

  regfile_writeback_queue_if #(.BITS_SIZE(BITS_SIZE), .DEPTH(DEPTH)) bus ();

  regfile_writeback_queue #(.BITS_SIZE(BITS_SIZE), .DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void modelReset();
    mq.delete();
    mWe   = 1'b0;
    mReg  = '0;
    mData = '0;
  endfunction

  // Youngest queued entry first, then the entry sitting on the write port.
  function automatic void modelLookup(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (r == 5'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].r == r) begin
        hit = 1'b1;
        d   = mq[i].d;
        return;
      end
    end
    if (mWe && mReg == r) begin
      hit = 1'b1;
      d   = mData;
    end
  endfunction

  // One clock edge; the model sees the same inputs the DUT samples.
  task automatic tick();
    bit     doPush, doPop;
    entry_t e, h;
    doPush = bus.InValid && (mq.size() < DEPTH) && (bus.InRegister != 5'd0);
    doPop  = (mq.size() > 0) && !bus.Hold;
    e.r = bus.InRegister;
    e.d = bus.InData;
    @(posedge Clk);
    if (doPop) begin
      h     = mq.pop_front();
      mWe   = 1'b1;
      mReg  = h.r;
      mData = h.d;
    end else begin
      mWe = 1'b0;
    end
    if (doPush) mq.push_back(e);
    #1;
  endtask

  task automatic offer(input logic [4:0] r, input logic [31:0] d);
    bus.InValid    = 1'b1;
    bus.InRegister = r;
    bus.InData     = d;
  endtask

  task automatic drain();
    bus.InValid = 1'b0;
    bus.Hold    = 1'b0;
    repeat (DEPTH + 2) tick();
  endtask

  task automatic test_reset();
    Rst_n              = 1'b0;
    bus.InValid        = 1'b0;
    bus.InRegister     = '0;
    bus.InData         = '0;
    bus.Hold           = 1'b0;
    bus.LookupRegister = '0;
    modelReset();
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (c == 3) Rst_n = 1'b1;
      checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_regwrite: got %0b expected 0", bus.RegWrite); end
      checks++; if (bus.WriteRegister !== 5'd0) begin failures++; $display("[TB] FAIL reset_wreg: got %0d expected 0", bus.WriteRegister); end
      checks++; if (bus.WriteData !== 32'd0) begin failures++; $display("[TB] FAIL reset_wdata: got %0h expected 0", bus.WriteData); end
      checks++; if (bus.Count !== CW'(0)) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.Count); end
      checks++; if (bus.InReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_inready: got %0b expected 1", bus.InReady); end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_single_write();
    offer(5'd8, 32'hDEADBEEF);
    tick();
    bus.InValid = 1'b0;
    checks++; if (bus.Count !== CW'(1)) begin failures++; $display("[TB] FAIL single_count1: got %0d expected 1", bus.Count); end
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL single_early: got %0b expected 0", bus.RegWrite); end
    tick();
    checks++; if (bus.RegWrite !== 1'b1) begin failures++; $display("[TB] FAIL single_we: got %0b expected 1", bus.RegWrite); end
    checks++; if (bus.WriteRegister !== 5'd8) begin failures++; $display("[TB] FAIL single_wreg: got %0d expected 8", bus.WriteRegister); end
    checks++; if (bus.WriteData !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_wdata: got %0h expected deadbeef", bus.WriteData); end
    checks++; if (bus.Count !== CW'(0)) begin failures++; $display("[TB] FAIL single_count0: got %0d expected 0", bus.Count); end
    tick();
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL single_oneshot: got %0b expected 0", bus.RegWrite); end
    checks++; if (bus.WriteRegister !== 5'd8) begin failures++; $display("[TB] FAIL single_hold_wreg: got %0d expected 8", bus.WriteRegister); end
  endtask

  task automatic test_fill_wrap();
    bus.Hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(5'(9 + k), 32'(k + 1));
      tick();
    end
    checks++; if (bus.Count !== CW'(4)) begin failures++; $display("[TB] FAIL fill_count: got %0d expected 4", bus.Count); end
    checks++; if (bus.InReady !== 1'b0) begin failures++; $display("[TB] FAIL fill_inready: got %0b expected 0", bus.InReady); end
    offer(5'd13, 32'd5);
    tick();
    checks++; if (bus.Count !== CW'(4)) begin failures++; $display("[TB] FAIL fill_reject: got %0d expected 4", bus.Count); end
    bus.InValid = 1'b0;
    bus.Hold    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.RegWrite !== 1'b1) begin failures++; $display("[TB] FAIL fill_we%0d: got %0b expected 1", k, bus.RegWrite); end
      checks++; if (bus.WriteRegister !== 5'(9 + k)) begin failures++; $display("[TB] FAIL fill_wreg%0d: got %0d expected %0d", k, bus.WriteRegister, 9 + k); end
      checks++; if (bus.WriteData !== 32'(k + 1)) begin failures++; $display("[TB] FAIL fill_wdata%0d: got %0h expected %0h", k, bus.WriteData, k + 1); end
    end
    offer(5'd13, 32'hA13);
    tick();
    offer(5'd14, 32'hA14);
    tick();
    bus.InValid = 1'b0;
    checks++; if (bus.WriteRegister !== 5'd13 || bus.WriteData !== 32'hA13 || bus.RegWrite !== 1'b1) begin failures++; $display("[TB] FAIL wrap_first: got r%0d=%0h we%0b expected r13=a13 we1", bus.WriteRegister, bus.WriteData, bus.RegWrite); end
    tick();
    checks++; if (bus.WriteRegister !== 5'd14 || bus.WriteData !== 32'hA14 || bus.RegWrite !== 1'b1) begin failures++; $display("[TB] FAIL wrap_second: got r%0d=%0h we%0b expected r14=a14 we1", bus.WriteRegister, bus.WriteData, bus.RegWrite); end
    tick();
  endtask

  task automatic test_zero_reg();
    offer(5'd0, 32'd5);
    #1;
    checks++; if (bus.InReady !== 1'b1) begin failures++; $display("[TB] FAIL zero_ready: got %0b expected 1", bus.InReady); end
    tick();
    bus.InValid = 1'b0;
    checks++; if (bus.Count !== CW'(0)) begin failures++; $display("[TB] FAIL zero_count: got %0d expected 0", bus.Count); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL zero_we: got %0b expected 0", bus.RegWrite); end
    end
    bus.LookupRegister = 5'd0;
    #1;
    checks++; if (bus.LookupHit !== 1'b0) begin failures++; $display("[TB] FAIL zero_lookup: got %0b expected 0", bus.LookupHit); end
  endtask

  task automatic test_bypass();
    bus.Hold = 1'b1;
    offer(5'd16, 32'd7);
    tick();
    offer(5'd16, 32'd9);
    tick();
    bus.InValid        = 1'b0;
    bus.LookupRegister = 5'd16;
    #1;
    checks++; if (bus.LookupHit !== 1'b1 || bus.LookupData !== 32'd9) begin failures++; $display("[TB] FAIL bypass_newest: got hit%0b data %0h expected hit1 data 9", bus.LookupHit, bus.LookupData); end
    bus.LookupRegister = 5'd17;
    #1;
    checks++; if (bus.LookupHit !== 1'b0 || bus.LookupData !== 32'd0) begin failures++; $display("[TB] FAIL bypass_miss: got hit%0b data %0h expected hit0 data 0", bus.LookupHit, bus.LookupData); end
    bus.Hold = 1'b0;
    tick();
    bus.Hold           = 1'b1;
    bus.LookupRegister = 5'd16;
    #1;
    checks++; if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd16 || bus.WriteData !== 32'd7) begin failures++; $display("[TB] FAIL bypass_out: got we%0b r%0d=%0h expected we1 r16=7", bus.RegWrite, bus.WriteRegister, bus.WriteData); end
    checks++; if (bus.LookupHit !== 1'b1 || bus.LookupData !== 32'd9) begin failures++; $display("[TB] FAIL bypass_prio: got hit%0b data %0h expected hit1 data 9", bus.LookupHit, bus.LookupData); end
    bus.Hold = 1'b0;
    tick();
    checks++; if (bus.LookupHit !== 1'b1 || bus.LookupData !== 32'd9) begin failures++; $display("[TB] FAIL bypass_outreg: got hit%0b data %0h expected hit1 data 9", bus.LookupHit, bus.LookupData); end
    tick();
    checks++; if (bus.LookupHit !== 1'b0 || bus.LookupData !== 32'd0) begin failures++; $display("[TB] FAIL bypass_gone: got hit%0b data %0h expected hit0 data 0", bus.LookupHit, bus.LookupData); end
  endtask

  task automatic test_random();
    logic        expHit;
    logic [31:0] expData;
    for (int c = 0; c < 400; c++) begin
      bus.InValid        = ($urandom_range(0, 3) != 0);
      bus.InRegister     = 5'($urandom_range(0, 7));
      bus.InData         = $urandom;
      bus.Hold           = ($urandom_range(0, 3) == 0);
      bus.LookupRegister = 5'($urandom_range(0, 7));
      #1;
      modelLookup(bus.LookupRegister, expHit, expData);
      checks++; if (bus.InReady !== (mq.size() < DEPTH)) begin failures++; $display("[TB] FAIL rand_ready c%0d: got %0b expected %0b", c, bus.InReady, mq.size() < DEPTH); end
      checks++; if (bus.LookupHit !== expHit || bus.LookupData !== expData) begin failures++; $display("[TB] FAIL rand_lookup c%0d r%0d: got hit%0b %0h expected hit%0b %0h", c, bus.LookupRegister, bus.LookupHit, bus.LookupData, expHit, expData); end
      tick();
      checks++; if (bus.RegWrite !== mWe) begin failures++; $display("[TB] FAIL rand_we c%0d: got %0b expected %0b", c, bus.RegWrite, mWe); end
      checks++; if (bus.WriteRegister !== mReg || bus.WriteData !== mData) begin failures++; $display("[TB] FAIL rand_write c%0d: got r%0d=%0h expected r%0d=%0h", c, bus.WriteRegister, bus.WriteData, mReg, mData); end
      checks++; if (bus.Count !== CW'(mq.size())) begin failures++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, bus.Count, mq.size()); end
    end
    bus.LookupRegister = '0;
  endtask

  task automatic test_async_reset();
    bus.Hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(5'(20 + k), 32'(100 + k));
      tick();
    end
    bus.InValid = 1'b0;
    bus.Hold    = 1'b0;
    tick();
    checks++; if (bus.RegWrite !== 1'b1 || bus.Count !== CW'(3)) begin failures++; $display("[TB] FAIL areset_pre: got we%0b count %0d expected we1 count 3", bus.RegWrite, bus.Count); end
    #3;
    Rst_n = 1'b0;
    modelReset();
    #1;
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("[TB] FAIL areset_we: got %0b expected 0", bus.RegWrite); end
    checks++; if (bus.Count !== CW'(0)) begin failures++; $display("[TB] FAIL areset_count: got %0d expected 0", bus.Count); end
    checks++; if (bus.WriteRegister !== 5'd0 || bus.WriteData !== 32'd0) begin failures++; $display("[TB] FAIL areset_wport: got r%0d=%0h expected r0=0", bus.WriteRegister, bus.WriteData); end
    @(posedge Clk);
    #3;
    Rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (bus.RegWrite !== 1'b0 || bus.Count !== CW'(0)) begin failures++; $display("[TB] FAIL areset_after c%0d: got we%0b count %0d expected we0 count 0", c, bus.RegWrite, bus.Count); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_write();
    drain();
    test_fill_wrap();
    drain();
    test_zero_reg();
    drain();
    test_bypass();
    drain();
    test_random();
    drain();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
